// File: rtl/cnn_feeder_pkg.sv
// Shared types and constants for the CNN image feeder.
package cnn_feeder_pkg;

  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    CNN_RST  = 3'd1,
    STREAM   = 3'd2,
    WAIT_DEC = 3'd3,
    DONE     = 3'd4
  } feeder_state_t;

  localparam int         NUM_PIXELS_C     = 784;
  localparam logic [3:0] TIMEOUT_RESULT_C = 4'hF;

endpackage

// File: rtl/cnn_feeder_pixel_ram.sv
// Single-port image buffer: synchronous write, synchronous read (1-cycle latency).
// Kept free of resets so it maps onto a block RAM.
module cnn_feeder_pixel_ram #(
  parameter int DEPTH     = 784,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);

  logic [7:0] mem [0:DEPTH-1];

  // Write on we, registered read on re; the two never overlap in use.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/cnn_image_feeder.sv
// Buffers one 28x28 image from a byte stream, resets the CNN, streams the
// image one pixel per clock and captures the comparator decision.
// Optional feature: define CNN_FEEDER_TIMEOUT_EN to enable the decision
// watchdog (result 4'hF, timeout=1 after TIMEOUT_CYCLES WAIT_DEC cycles).
//
// Handshake: a byte transfers on a rising edge where s_valid && s_ready are
// both high; s_ready does not depend on s_valid, and the source must hold
// s_data stable while s_valid is high.
module cnn_image_feeder
  import cnn_feeder_pkg::*;
#(
  parameter int NUM_PIXELS     = NUM_PIXELS_C,
  parameter int ADDR_BITS      = 10,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [7:0]    s_data,
  output logic          cnn_rst_n,
  output logic [7:0]    pixel_out,
  input  logic          dec_valid,
  input  logic [3:0]    dec_in,
  output logic          result_valid,
  output logic [3:0]    result,
  output logic          timeout,
  output logic [15:0]   img_count,
  output logic          busy,
  output feeder_state_t dbg_state
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);

  feeder_state_t        state_q, state_d;
  logic [ADDR_BITS-1:0] idx_q;
  logic [RC_W-1:0]      rst_cnt_q;
  logic                 idx_last;
  logic                 accept;
  logic                 ram_re;
  logic                 dec_take;
  logic                 wd_expired;
  logic                 rd_valid_q;
  logic [7:0]           ram_rdata;

  assign idx_last  = (idx_q == ADDR_BITS'(NUM_PIXELS - 1));
  assign dbg_state = state_q;

`ifdef CNN_FEEDER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt_q;
  logic            timeout_q;

  assign wd_expired = (state_q == WAIT_DEC) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout    = timeout_q;

  // Watchdog counts WAIT_DEC cycles; cleared in every other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else if (state_q == WAIT_DEC) begin
      wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end else begin
      wd_cnt_q <= '0;
    end
  end

  // Timeout flag travels with result and holds until the next DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (state_q == WAIT_DEC && state_d == DONE) begin
      timeout_q <= !dec_take;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign timeout    = 1'b0;
`endif

  // Next-state and per-cycle strobes.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    ram_re   = 1'b0;
    dec_take = 1'b0;
    case (state_q)
      LOAD: begin
        accept = s_valid && s_ready;
        if (accept && idx_last) state_d = CNN_RST;
      end
      CNN_RST: begin
        if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) state_d = STREAM;
      end
      STREAM: begin
        ram_re = 1'b1;
        if (idx_last) state_d = WAIT_DEC;
      end
      WAIT_DEC: begin
        if (dec_valid) begin
          dec_take = 1'b1;
          state_d  = DONE;
        end else if (wd_expired) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // State register plus the shared pixel index and CNN reset counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      rst_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        LOAD:    if (accept) idx_q <= idx_last ? '0 : idx_q + ADDR_BITS'(1);
        STREAM:  idx_q <= idx_last ? '0 : idx_q + ADDR_BITS'(1);
        default: idx_q <= '0;
      endcase
      rst_cnt_q <= (state_q == CNN_RST) ? rst_cnt_q + RC_W'(1) : '0;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready      <= 1'b0;
      cnn_rst_n    <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      rd_valid_q   <= 1'b0;
      result       <= '0;
      img_count    <= '0;
    end else begin
      s_ready      <= (state_d == LOAD);
      cnn_rst_n    <= (state_d == STREAM) || (state_d == WAIT_DEC);
      busy         <= (state_d != LOAD);
      result_valid <= (state_d == DONE);
      rd_valid_q   <= ram_re;
      if (state_q == WAIT_DEC && state_d == DONE) begin
        result    <= dec_take ? dec_in : TIMEOUT_RESULT_C;
        img_count <= img_count + 16'd1;
      end
    end
  end

  // RAM output register is the pixel register; zero whenever no read landed.
  assign pixel_out = rd_valid_q ? ram_rdata : 8'h00;

  cnn_feeder_pixel_ram #(
    .DEPTH     (NUM_PIXELS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .re    (ram_re),
    .addr  (idx_q),
    .wdata (s_data),
    .rdata (ram_rdata)
  );

endmodule
